// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state type for the UART transmit feeder
package uart_pkg;

    localparam int DEPTH_DEF  = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - circular byte FIFO with occupancy count and sticky overflow flag
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              wr_ok;
    logic              rd_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rptr];

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_ff @(posedge clk) begin
        if (rst && wr_ok) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (wr_en && !wr_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - feeds buffered bytes to a UART transmitter with a send/donetx handshake
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [DATA_W-1:0]        dintx,
    output logic                     send,
    input  logic                     donetx,
    output logic                     idle
);

    tx_state_e         state;
    tx_state_e         state_next;
    logic              send_next;
    logic [DATA_W-1:0] dintx_next;
    logic              donetx_q;
    logic              done_rise;
    logic              pop;
    logic              empty;
    logic [DATA_W-1:0] head;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    // donetx_q resets high so a level already high at release is not a rising edge.
    assign done_rise = donetx && !donetx_q;
    assign idle      = (state == IDLE) && empty;

    always_comb begin
        state_next = state;
        send_next  = send;
        dintx_next = dintx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = SEND;
                    send_next  = 1'b1;
                    dintx_next = head;
                end else begin
                    send_next  = 1'b0;
                    dintx_next = '0;
                end
            end
            SEND: begin
                if (done_rise) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                    send_next  = 1'b0;
                    dintx_next = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            send     <= 1'b0;
            dintx    <= '0;
            donetx_q <= 1'b1;
        end else begin
            state    <= state_next;
            send     <= send_next;
            dintx    <= dintx_next;
            donetx_q <= donetx;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       donetx;
    logic       full;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] dintx;
    logic       send;
    logic       idle;

    int total = 0;
    int bad   = 0;

    uart_tx_feeder #(
        .DEPTH  (16),
        .DATA_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .level    (level),
        .overflow (overflow),
        .dintx    (dintx),
        .send     (send),
        .donetx   (donetx),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wr_en;
        logic [7:0] wr_data;
        logic       donetx;
        logic       e_send;
        logic [7:0] e_dintx;
        logic [4:0] e_level;
        logic       e_full;
        logic       e_ovf;
        logic       e_idle;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_send(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (send === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; wr_en = 1'b0; donetx = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic frame(input logic [7:0] exp);
        bit ok;
        wait_send(ok);
        chk("send_timeout", 32'(ok), 1);
        chk("frame_data", 32'(dintx), 32'(exp));
        tick();
        chk("frame_hold", 32'({send, dintx}), 32'({1'b1, exp}));
        donetx = 1'b1;
        tick();
        chk("frame_end_send", 32'(send), 0);
        donetx = 1'b0;
    endtask

    initial begin
        // rst wr_en data donetx | send dintx level full ovf idle
        vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1};

        rst = 1'b0; wr_en = 1'b0; wr_data = '0; donetx = 1'b0;
        #2;
        for (int v = 0; v < 11; v++) begin
            rst = vecs[v].rst; wr_en = vecs[v].wr_en;
            wr_data = vecs[v].wr_data; donetx = vecs[v].donetx;
            tick();
            chk($sformatf("vec%0d_send", v),  32'(send),     32'(vecs[v].e_send));
            chk($sformatf("vec%0d_dintx", v), 32'(dintx),    32'(vecs[v].e_dintx));
            chk($sformatf("vec%0d_level", v), 32'(level),    32'(vecs[v].e_level));
            chk($sformatf("vec%0d_full", v),  32'(full),     32'(vecs[v].e_full));
            chk($sformatf("vec%0d_ovf", v),   32'(overflow), 32'(vecs[v].e_ovf));
            chk($sformatf("vec%0d_idle", v),  32'(idle),     32'(vecs[v].e_idle));
        end

        // Burst of three with a one-clock send gap between frames
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk("burst_send", 32'(send), 1);
            chk("burst_data", 32'(dintx), i);
            tick(); tick();
            donetx = 1'b1;
            tick();
            chk("burst_gap_send", 32'(send), 0);
            chk("burst_gap_dintx", 32'(dintx), 0);
            donetx = 1'b0;
            if (i < 3) tick();
        end
        chk("burst_level", 32'(level), 0);
        chk("burst_idle", 32'(idle), 1);

        // Fill to 16, seventeenth write dropped
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            tick();
            if (i == 14) chk("fill15_full", 32'({full, level}), 32'({1'b0, 5'd15}));
            if (i == 15) chk("fill16_state", 32'({full, overflow, level}), 32'({1'b1, 1'b0, 5'd16}));
        end
        wr_en = 1'b0;
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_level", 32'(level), 16);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_head", 32'({send, dintx}), 32'({1'b1, 8'h10}));

        // Full FIFO: write coincides with pop, then drain across pointer wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h20 + i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        chk("simul_pre", 32'({send, dintx, full}), 32'({1'b1, 8'h20, 1'b1}));
        wr_en = 1'b1; wr_data = 8'h99; donetx = 1'b1;
        tick();
        wr_en = 1'b0; donetx = 1'b0;
        chk("simul_level", 32'(level), 16);
        chk("simul_ovf", 32'(overflow), 0);
        chk("simul_send", 32'(send), 0);
        for (int i = 1; i < 16; i++) frame(8'(8'h20 + i));
        frame(8'h99);
        tick();
        chk("wrap_level", 32'(level), 0);
        chk("wrap_idle", 32'(idle), 1);

        // Reset mid-frame, then a late donetx pulse must not pop anything
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            tick();
        end
        wr_en = 1'b0;
        chk("mid_pre", 32'({send, level}), 32'({1'b1, 5'd4}));
        rst = 1'b0;
        tick();
        chk("mid_rst", 32'({send, level, dintx}), 32'({1'b0, 5'd0, 8'h00}));
        rst = 1'b1;
        tick();
        donetx = 1'b1;
        tick();
        donetx = 1'b0;
        tick();
        tick();
        chk("mid_level", 32'(level), 0);
        chk("mid_send", 32'(send), 0);
        chk("mid_idle", 32'(idle), 1);
        chk("mid_ovf", 32'(overflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
